riffa_cmd_sequencer: RTL and testbench

RIFFA_CMD_SEQUENCER -- requirements
Module: riffa_cmd_sequencer

---
 rtl/riffa_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_riffa_cmd_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/riffa_cmd_sequencer.sv
// RIFFA command sequencer: takes a host command on the RX channel, optionally streams
// req_len words from a local source on DATA_TX, then returns a two-word status on CMD_TX.
//
// state    | meaning
// IDLE     | waiting for CMD_RX
// RX_ACK   | one-cycle CMD_RX_ACK pulse
// RX_DATA  | draining command words (opcode, req_len, extras discarded)
// CHECK    | evaluate status code, set ERR on failure
// DTX_REQ  | request DATA_TX, wait for DATA_TX_ACK
// DTX_DATA | pass SRC stream through to DATA_TX for req_len words
// STX_REQ  | request CMD_TX, wait for CMD_TX_ACK
// STX_DATA | send status word and transfer-count word
module riffa_cmd_sequencer #(
   parameter logic [31:0] MAX_LEN = 32'h0010_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_RX,
   output logic        CMD_RX_ACK,
   input  logic        CMD_RX_LAST,
   input  logic [31:0] CMD_RX_LEN,
   input  logic [30:0] CMD_RX_OFF,
   input  logic [31:0] CMD_RX_DATA,
   input  logic        CMD_RX_DATA_VALID,
   output logic        CMD_RX_DATA_REN,
   output logic        CMD_TX,
   input  logic        CMD_TX_ACK,
   output logic        CMD_TX_LAST,
   output logic [31:0] CMD_TX_LEN,
   output logic [30:0] CMD_TX_OFF,
   output logic [31:0] CMD_TX_DATA,
   output logic        CMD_TX_DATA_VALID,
   input  logic        CMD_TX_DATA_REN,
   output logic        DATA_TX,
   input  logic        DATA_TX_ACK,
   output logic        DATA_TX_LAST,
   output logic [31:0] DATA_TX_LEN,
   output logic [30:0] DATA_TX_OFF,
   output logic [31:0] DATA_TX_DATA,
   output logic        DATA_TX_DATA_VALID,
   input  logic        DATA_TX_DATA_REN,
   input  logic [31:0] SRC_DATA,
   input  logic        SRC_VALID,
   output logic        SRC_READY,
   output logic        BUSY,
   output logic        ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_ACK, S_RX_DATA, S_CHECK, S_DTX_REQ, S_DTX_DATA, S_STX_REQ, S_STX_DATA
   } state_t;

   state_t      state, state_nx;
   logic [31:0] rx_len, rx_cnt, req_len, xfer_cnt;
   logic [7:0]  opcode, status, status_chk;
   logic        word_sel, err;
   logic        unused_rx_meta;

   // host-side framing hints carry no meaning for this command format
   assign unused_rx_meta = ^{CMD_RX_LAST, CMD_RX_OFF};

   always_comb begin
      status_chk = 8'h00;
      if (rx_len != 32'd2)                              status_chk = 8'h01;
      else if (opcode != 8'h01 && opcode != 8'h02)      status_chk = 8'h02;
      else if (opcode == 8'h01 && req_len == 32'd0)     status_chk = 8'h03;
      else if (opcode == 8'h01 && req_len > MAX_LEN)    status_chk = 8'h04;
   end

   always_comb begin
      state_nx           = state;
      CMD_RX_ACK         = 1'b0;
      CMD_RX_DATA_REN    = 1'b0;
      CMD_TX             = 1'b0;
      CMD_TX_LAST        = 1'b0;
      CMD_TX_LEN         = 32'd0;
      CMD_TX_OFF         = 31'd0;
      CMD_TX_DATA        = 32'd0;
      CMD_TX_DATA_VALID  = 1'b0;
      DATA_TX            = 1'b0;
      DATA_TX_LAST       = 1'b0;
      DATA_TX_LEN        = 32'd0;
      DATA_TX_OFF        = 31'd0;
      DATA_TX_DATA       = 32'd0;
      DATA_TX_DATA_VALID = 1'b0;
      SRC_READY          = 1'b0;
      case (state)
         S_IDLE:    if (CMD_RX) state_nx = S_RX_ACK;
         S_RX_ACK: begin
            CMD_RX_ACK = 1'b1;
            state_nx   = (rx_len == 32'd0) ? S_CHECK : S_RX_DATA;
         end
         S_RX_DATA: begin
            CMD_RX_DATA_REN = 1'b1;
            if (CMD_RX_DATA_VALID && rx_cnt == rx_len - 32'd1) state_nx = S_CHECK;
         end
         S_CHECK:
            state_nx = (status_chk == 8'h00 && opcode == 8'h01) ? S_DTX_REQ : S_STX_REQ;
         S_DTX_REQ: begin
            DATA_TX      = 1'b1;
            DATA_TX_LAST = 1'b1;
            DATA_TX_LEN  = req_len;
            if (DATA_TX_ACK) state_nx = S_DTX_DATA;
         end
         S_DTX_DATA: begin
            DATA_TX            = 1'b1;
            DATA_TX_LAST       = 1'b1;
            DATA_TX_LEN        = req_len;
            DATA_TX_DATA       = SRC_DATA;
            DATA_TX_DATA_VALID = SRC_VALID;
            SRC_READY          = DATA_TX_DATA_REN;
            if (SRC_VALID && DATA_TX_DATA_REN && xfer_cnt == req_len - 32'd1)
               state_nx = S_STX_REQ;
         end
         S_STX_REQ: begin
            CMD_TX      = 1'b1;
            CMD_TX_LAST = 1'b1;
            CMD_TX_LEN  = 32'd2;
            if (CMD_TX_ACK) state_nx = S_STX_DATA;
         end
         S_STX_DATA: begin
            CMD_TX            = 1'b1;
            CMD_TX_LAST       = 1'b1;
            CMD_TX_LEN        = 32'd2;
            CMD_TX_DATA_VALID = 1'b1;
            CMD_TX_DATA       = word_sel ? xfer_cnt : {status, opcode, 16'h0000};
            if (CMD_TX_DATA_REN && word_sel) state_nx = S_IDLE;
         end
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         rx_len   <= 32'd0;
         rx_cnt   <= 32'd0;
         req_len  <= 32'd0;
         xfer_cnt <= 32'd0;
         opcode   <= 8'h00;
         status   <= 8'h00;
         word_sel <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (CMD_RX) begin
               rx_len   <= CMD_RX_LEN;
               rx_cnt   <= 32'd0;
               req_len  <= 32'd0;
               xfer_cnt <= 32'd0;
               opcode   <= 8'h00;
               status   <= 8'h00;
               word_sel <= 1'b0;
            end
            S_RX_DATA: if (CMD_RX_DATA_VALID) begin
               if (rx_cnt == 32'd0) opcode  <= CMD_RX_DATA[7:0];
               if (rx_cnt == 32'd1) req_len <= CMD_RX_DATA;
               rx_cnt <= rx_cnt + 32'd1;
            end
            S_CHECK: begin
               status <= status_chk;
               if (status_chk != 8'h00) err <= 1'b1;
            end
            S_DTX_DATA: if (SRC_VALID && DATA_TX_DATA_REN) xfer_cnt <= xfer_cnt + 32'd1;
            S_STX_DATA: if (CMD_TX_DATA_REN) word_sel <= 1'b1;
            default: ;
         endcase
      end
   end

   assign BUSY = (state != S_IDLE);
   assign ERR  = err;

endmodule

// File: tb/tb_riffa_cmd_sequencer.sv
// Directed bench for riffa_cmd_sequencer: expected DATA_TX words and status words are
// queued as each command is driven and popped by a monitor when the DUT hands them off.
module tb_riffa_cmd_sequencer;
   localparam logic [31:0] MAX_LEN = 32'h0010_0000;

   logic        CLK = 1'b0, RST;
   logic        CMD_RX, CMD_RX_ACK, CMD_RX_LAST, CMD_RX_DATA_VALID, CMD_RX_DATA_REN;
   logic [31:0] CMD_RX_LEN, CMD_RX_DATA;
   logic [30:0] CMD_RX_OFF;
   logic        CMD_TX, CMD_TX_ACK, CMD_TX_LAST, CMD_TX_DATA_VALID, CMD_TX_DATA_REN;
   logic [31:0] CMD_TX_LEN, CMD_TX_DATA;
   logic [30:0] CMD_TX_OFF;
   logic        DATA_TX, DATA_TX_ACK, DATA_TX_LAST, DATA_TX_DATA_VALID, DATA_TX_DATA_REN;
   logic [31:0] DATA_TX_LEN, DATA_TX_DATA;
   logic [30:0] DATA_TX_OFF;
   logic [31:0] SRC_DATA;
   logic        SRC_VALID, SRC_READY, BUSY, ERR;

   riffa_cmd_sequencer #(.MAX_LEN(MAX_LEN)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_RX(CMD_RX), .CMD_RX_ACK(CMD_RX_ACK), .CMD_RX_LAST(CMD_RX_LAST),
      .CMD_RX_LEN(CMD_RX_LEN), .CMD_RX_OFF(CMD_RX_OFF), .CMD_RX_DATA(CMD_RX_DATA),
      .CMD_RX_DATA_VALID(CMD_RX_DATA_VALID), .CMD_RX_DATA_REN(CMD_RX_DATA_REN),
      .CMD_TX(CMD_TX), .CMD_TX_ACK(CMD_TX_ACK), .CMD_TX_LAST(CMD_TX_LAST),
      .CMD_TX_LEN(CMD_TX_LEN), .CMD_TX_OFF(CMD_TX_OFF), .CMD_TX_DATA(CMD_TX_DATA),
      .CMD_TX_DATA_VALID(CMD_TX_DATA_VALID), .CMD_TX_DATA_REN(CMD_TX_DATA_REN),
      .DATA_TX(DATA_TX), .DATA_TX_ACK(DATA_TX_ACK), .DATA_TX_LAST(DATA_TX_LAST),
      .DATA_TX_LEN(DATA_TX_LEN), .DATA_TX_OFF(DATA_TX_OFF), .DATA_TX_DATA(DATA_TX_DATA),
      .DATA_TX_DATA_VALID(DATA_TX_DATA_VALID), .DATA_TX_DATA_REN(DATA_TX_DATA_REN),
      .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
      .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int          checks = 0, errors = 0;
   logic [31:0] exp_data[$];
   logic [31:0] exp_stat[$];
   int          ack_cnt = 0, dtx_cnt = 0;
   logic [31:0] dtx_len = 32'd0;
   logic        dtx_prev = 1'b0;
   logic [31:0] e_mon;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // handoff monitor; sampled on the falling edge, inputs change just after the rising edge
   always @(negedge CLK) begin
      if (!RST) begin
         if (DATA_TX_DATA_VALID && DATA_TX_DATA_REN) begin
            e_mon = (exp_data.size() > 0) ? exp_data.pop_front() : 32'hxxxx_xxxx;
            check("data_word", DATA_TX_DATA, e_mon);
         end
         if (CMD_TX_DATA_VALID && CMD_TX_DATA_REN) begin
            e_mon = (exp_stat.size() > 0) ? exp_stat.pop_front() : 32'hxxxx_xxxx;
            check("status_word", CMD_TX_DATA, e_mon);
         end
         if (CMD_RX_ACK) ack_cnt++;
         if (DATA_TX && !dtx_prev) begin
            dtx_cnt++;
            dtx_len = DATA_TX_LEN;
         end
      end
      dtx_prev = DATA_TX;
   end

   task automatic send_cmd(input logic [31:0] len, input logic [31:0] w0, w1, w2);
      logic [31:0] w[3];
      int n;
      w[0] = w0; w[1] = w1; w[2] = w2;
      CMD_RX = 1'b1;
      CMD_RX_LEN = len;
      n = 0;
      @(negedge CLK);
      while (!CMD_RX_ACK && n < 50) begin @(negedge CLK); n++; end
      check("rx_ack_seen", CMD_RX_ACK, 1);
      @(posedge CLK); #1;
      CMD_RX = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
         CMD_RX_DATA = w[i];
         CMD_RX_DATA_VALID = 1'b1;
         n = 0;
         @(negedge CLK);
         while (!CMD_RX_DATA_REN && n < 50) begin @(negedge CLK); n++; end
         check("rx_ren", CMD_RX_DATA_REN, 1);
         @(posedge CLK); #1;
      end
      CMD_RX_DATA_VALID = 1'b0;
      @(negedge CLK);
      check("rx_ren_off", CMD_RX_DATA_REN, 0);
      @(posedge CLK); #1;
   endtask

   task automatic run_src(input int nw, input logic [31:0] base, input bit bp, input bit full);
      int i, cyc;
      for (int k = 0; k < nw; k++) exp_data.push_back(base + 32'(k));
      i = 0; cyc = 0;
      while (i < nw && cyc < 500) begin
         SRC_DATA = base + 32'(i);
         SRC_VALID = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         DATA_TX_DATA_REN = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge CLK);
         if (SRC_VALID && SRC_READY) i++;
         @(posedge CLK); #1;
         cyc++;
      end
      check("src_words", 32'(i), 32'(nw));
      SRC_VALID = 1'b0;
      DATA_TX_DATA_REN = 1'b1;
      if (full) begin
         @(negedge CLK);
         check("src_ready_after", SRC_READY, 0);
         check("data_tx_after", DATA_TX, 0);
         @(posedge CLK); #1;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge CLK);
      while (BUSY && n < 200) begin @(negedge CLK); n++; end
      check("idle_reached", BUSY, 0);
      @(posedge CLK); #1;
   endtask

   task automatic run_cmd(input string tag, input logic [31:0] len, w0, w1, w2,
                          input int nsrc, input bit bp, input logic [31:0] s0, s1);
      int a0, d0;
      a0 = ack_cnt; d0 = dtx_cnt;
      exp_stat.push_back(s0);
      exp_stat.push_back(s1);
      send_cmd(len, w0, w1, w2);
      if (nsrc > 0) run_src(nsrc, 32'hA000_0000 + (bp ? 32'h100 : 32'h0), bp, 1'b1);
      wait_idle();
      check({tag, "_ack_pulses"}, 32'(ack_cnt - a0), 1);
      check({tag, "_dtx_reqs"}, 32'(dtx_cnt - d0), (nsrc > 0) ? 32'd1 : 32'd0);
      if (nsrc > 0) check({tag, "_dtx_len"}, dtx_len, 32'(nsrc));
      check({tag, "_stat_left"}, 32'(exp_stat.size()), 0);
      check({tag, "_data_left"}, 32'(exp_data.size()), 0);
   endtask

   initial begin
      RST = 1'b1;
      CMD_RX = 1'b0; CMD_RX_LAST = 1'b0; CMD_RX_LEN = 32'd0; CMD_RX_OFF = 31'd0;
      CMD_RX_DATA = 32'd0; CMD_RX_DATA_VALID = 1'b0;
      CMD_TX_ACK = 1'b1; CMD_TX_DATA_REN = 1'b1;
      DATA_TX_ACK = 1'b1; DATA_TX_DATA_REN = 1'b1;
      SRC_DATA = 32'd0; SRC_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_ctrl", {CMD_RX_ACK, CMD_RX_DATA_REN, CMD_TX, CMD_TX_DATA_VALID, DATA_TX,
                           DATA_TX_DATA_VALID, SRC_READY, BUSY, ERR}, 0);
      RST = 1'b0;
      @(posedge CLK); #1;

      run_cmd("ok", 32'd2, 32'h01, 32'd4, 32'd0, 4, 1'b0, 32'h0001_0000, 32'd4);
      check("ok_err", ERR, 0);
      run_cmd("bp", 32'd2, 32'h01, 32'd4, 32'd0, 4, 1'b1, 32'h0001_0000, 32'd4);
      check("bp_err", ERR, 0);
      run_cmd("badlen", 32'd3, 32'd1, 32'd4, 32'd9, 0, 1'b0, 32'h0101_0000, 32'd0);
      check("badlen_err", ERR, 1);
      run_cmd("ping", 32'd2, 32'h02, 32'd7, 32'd0, 0, 1'b0, 32'h0002_0000, 32'd0);
      run_cmd("badop", 32'd2, 32'h7F, 32'd4, 32'd0, 0, 1'b0, 32'h027F_0000, 32'd0);
      run_cmd("len0", 32'd2, 32'h01, 32'd0, 32'd0, 0, 1'b0, 32'h0301_0000, 32'd0);
      run_cmd("lenmax", 32'd2, 32'h01, MAX_LEN + 32'd1, 32'd0, 0, 1'b0, 32'h0401_0000, 32'd0);

      // abort a data phase after two words
      send_cmd(32'd2, 32'h01, 32'd4, 32'd0);
      run_src(2, 32'hC000_0000, 1'b0, 1'b0);
      RST = 1'b1;
      SRC_VALID = 1'b1;
      @(posedge CLK); #1;
      check("rst_ctrl", {CMD_RX_ACK, CMD_RX_DATA_REN, CMD_TX, CMD_TX_LAST, CMD_TX_DATA_VALID,
                         DATA_TX, DATA_TX_LAST, DATA_TX_DATA_VALID, SRC_READY, BUSY, ERR}, 0);
      check("rst_dtx_len", DATA_TX_LEN, 0);
      check("rst_dtx_data", DATA_TX_DATA, 0);
      check("rst_ctx_data", CMD_TX_DATA, 0);
      RST = 1'b0;
      SRC_VALID = 1'b0;
      @(posedge CLK); #1;
      check("rst_data_left", 32'(exp_data.size()), 0);
      run_cmd("after_rst", 32'd2, 32'h01, 32'd4, 32'd0, 4, 1'b0, 32'h0001_0000, 32'd4);
      check("after_rst_err", ERR, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
